// File: rtl/pixie_scandoubler.sv
// pixie_scandoubler
// Line-doubling scan converter for the CDP1861 Pixie video stream.
// Each incoming line (pixel + hblank) is captured into one bank of a
// ping-pong line buffer at the pixel rate. The previously captured line
// is replayed twice at the full clk rate from the other bank.
//
// Build option: define PIXIE_SCANLINES_EN to blank video on the second
// replay of every line (dark-scanline look). Without it both replays are
// identical.
module pixie_scandoubler #(
    parameter int MAX_LINE    = 128,
    parameter int DEFAULT_LEN = 112,
    parameter int HS_LEN      = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ce_pix_i,
    input  logic video_in_i,
    input  logic hsync_in_i,
    input  logic vsync_in_i,
    input  logic hblank_in_i,
    input  logic vblank_in_i,
    output logic video_out_o,
    output logic hsync_out_o,
    output logic vsync_out_o,
    output logic hblank_out_o,
    output logic vblank_out_o,
    output logic de_out_o,
    output logic line_phase_o
);

    localparam int         IDX_W      = $clog2(MAX_LINE);
    localparam logic [7:0] MAX_LINE_C = 8'(MAX_LINE);
    localparam logic [7:0] DEF_LEN_C  = 8'(DEFAULT_LEN);
    localparam logic [7:0] HS_LEN_C   = 8'(HS_LEN);

    // Line buffer: bank select is the MSB of the address.
    logic [1:0]     line_mem [0:2*MAX_LINE-1];

    logic           hs_q;
    logic           ls;

    logic [7:0]     in_x_q,       in_x_d;
    logic [7:0]     in_len_q,     in_len_d;
    logic           wbank_q,      wbank_d;
    logic [7:0]     out_x_q,      out_x_d;
    logic           line_phase_q, line_phase_d;
    logic           vsync_q,      vsync_d;
    logic           vblank_q,     vblank_d;

    logic           wr_en;
    logic [IDX_W:0] wr_addr;
    logic [1:0]     wr_data;
    logic [IDX_W:0] rd_addr;

    logic [1:0]     rd_q;
    logic [7:0]     px_q;
    logic           video_gate;

    logic           video_q;
    logic           hblank_q;
    logic           hsync_q;
    logic           de_q;

    // Rising edge of the input hsync marks a line start, independent of ce_pix.
    assign ls = hsync_in_i & ~hs_q;

    // Write side: capture pixels into the write bank, measure line length on LS.
    always_comb begin
        in_x_d   = in_x_q;
        in_len_d = in_len_q;
        wbank_d  = wbank_q;
        wr_en    = 1'b0;
        wr_addr  = {wbank_q, in_x_q[IDX_W-1:0]};
        wr_data  = {video_in_i, hblank_in_i};
        vsync_d  = vsync_q;
        vblank_d = vblank_q;

        if (ls) begin
            wbank_d  = ~wbank_q;
            vsync_d  = vsync_in_i;
            vblank_d = vblank_in_i;
            if (in_x_q < 8'd2) begin
                in_len_d = 8'd2;
            end else if (in_x_q > MAX_LINE_C) begin
                in_len_d = MAX_LINE_C;
            end else begin
                in_len_d = in_x_q;
            end
            in_x_d = 8'd0;
            // A pixel coincident with LS is the first pixel of the new line.
            if (ce_pix_i) begin
                wr_en   = 1'b1;
                wr_addr = {~wbank_q, {IDX_W{1'b0}}};
                in_x_d  = 8'd1;
            end
        end else if (ce_pix_i && (in_x_q < MAX_LINE_C)) begin
            // Beyond MAX_LINE the counter parks and nothing is written.
            wr_en  = 1'b1;
            in_x_d = in_x_q + 8'd1;
        end
    end

    // Read side: replay counter wraps every in_len clocks, LS forces a restart.
    always_comb begin
        out_x_d      = out_x_q + 8'd1;
        line_phase_d = line_phase_q;
        rd_addr      = {~wbank_q, out_x_q[IDX_W-1:0]};

        if (ls) begin
            out_x_d      = 8'd0;
            line_phase_d = 1'b0;
        end else if (out_x_q == (in_len_q - 8'd1)) begin
            // Free-running wrap keeps the output periodic if the input stalls.
            out_x_d      = 8'd0;
            line_phase_d = ~line_phase_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hs_q         <= 1'b0;
            in_x_q       <= 8'd0;
            in_len_q     <= DEF_LEN_C;
            wbank_q      <= 1'b0;
            out_x_q      <= 8'd0;
            line_phase_q <= 1'b0;
            vsync_q      <= 1'b0;
            vblank_q     <= 1'b0;
        end else begin
            hs_q         <= hsync_in_i;
            in_x_q       <= in_x_d;
            in_len_q     <= in_len_d;
            wbank_q      <= wbank_d;
            out_x_q      <= out_x_d;
            line_phase_q <= line_phase_d;
            vsync_q      <= vsync_d;
            vblank_q     <= vblank_d;
        end
    end

    // Line buffer RAM: one write port, one registered read port, no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            line_mem[wr_addr] <= wr_data;
        end
        rd_q <= line_mem[rd_addr];
    end

`ifdef PIXIE_SCANLINES_EN
    logic phase_p1_q;

    // Phase travels with the read data so blanking lines up with the pixels.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_p1_q <= 1'b0;
        end else begin
            phase_p1_q <= line_phase_q;
        end
    end

    assign video_gate = rd_q[1] & ~phase_p1_q;
`else
    assign video_gate = rd_q[1];
`endif

    // Output stage: pixel, blanking and hsync share the same two-clock pipeline.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            px_q     <= 8'd0;
            video_q  <= 1'b0;
            hblank_q <= 1'b0;
            hsync_q  <= 1'b0;
            de_q     <= 1'b0;
        end else begin
            px_q     <= out_x_q;
            video_q  <= video_gate;
            hblank_q <= rd_q[0];
            hsync_q  <= (px_q < HS_LEN_C);
            // Registered so it matches ~hblank & ~vblank yet still reads 0 in reset.
            de_q     <= ~rd_q[0] & ~vblank_d;
        end
    end

    assign video_out_o  = video_q;
    assign hsync_out_o  = hsync_q;
    assign hblank_out_o = hblank_q;
    assign de_out_o     = de_q;
    assign vsync_out_o  = vsync_q;
    assign vblank_out_o = vblank_q;
    assign line_phase_o = line_phase_q;

endmodule

// File: tb/tb_pixie_scandoubler.sv
// Bench for pixie_scandoubler. The reference model thinks in whole lines:
// it keeps the pixels captured since the last line start, and predicts the
// output at every edge from the distance to the last line start and the
// length of the line being replayed.
module tb_pixie_scandoubler;

    logic clk_i = 1'b0;
    logic reset_i;
    logic ce_pix_i, video_in_i, hsync_in_i, vsync_in_i, hblank_in_i, vblank_in_i;
    logic video_out_o, hsync_out_o, vsync_out_o, hblank_out_o, vblank_out_o;
    logic de_out_o, line_phase_o;

    always #5 clk_i = ~clk_i;

    pixie_scandoubler dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ce_pix_i     (ce_pix_i),
        .video_in_i   (video_in_i),
        .hsync_in_i   (hsync_in_i),
        .vsync_in_i   (vsync_in_i),
        .hblank_in_i  (hblank_in_i),
        .vblank_in_i  (vblank_in_i),
        .video_out_o  (video_out_o),
        .hsync_out_o  (hsync_out_o),
        .vsync_out_o  (vsync_out_o),
        .hblank_out_o (hblank_out_o),
        .vblank_out_o (vblank_out_o),
        .de_out_o     (de_out_o),
        .line_phase_o (line_phase_o)
    );

    int vecs = 0;
    int miscompares = 0;
    int cyc = 0;
    bit in_rst = 1'b1;

    typedef logic [1:0] pix_t;
    // bit order: video, hsync, hblank, de, line_phase, vsync, vblank
    typedef struct {
        int         cyc;
        logic [6:0] obs;
        logic [6:0] exp;
        logic [6:0] mask;
    } ent_t;

    ent_t log_q[$];

    // Reference model state
    pix_t cur_q[$];
    bit   cur_valid;
    bit   hs_prev;
    bit   m_vs, m_vb;
    int   ctx_start, ctx_len, ctx_cnt;
    bit   ctx_valid, ctx_tim;
    pix_t ctx_data [128];
    int   prv_start, prv_len, prv_cnt;
    bit   prv_valid, prv_tim;
    pix_t prv_data [128];

    function automatic logic [6:0] obs_vec();
        return {video_out_o, hsync_out_o, hblank_out_o, de_out_o,
                line_phase_o, vsync_out_o, vblank_out_o};
    endfunction

    task automatic model_reset();
        cur_q.delete();
        cur_valid = 1'b0;
        hs_prev   = 1'b0;
        m_vs      = 1'b0;
        m_vb      = 1'b0;
        ctx_start = cyc;
        ctx_len   = 112;
        ctx_cnt   = 0;
        ctx_valid = 1'b0;
        ctx_tim   = 1'b1;
        prv_valid = 1'b0;
        prv_tim   = 1'b0;
        prv_start = 0;
        prv_len   = 112;
        prv_cnt   = 0;
    endtask

    // One clock: wait for the edge, advance the model, then record DUT vs model.
    task automatic tick();
        ent_t e;
        int   j, idx, ph, c_start, c_len, c_cnt;
        bit   c_valid, c_tim, use_ctx;
        pix_t px;
        logic v;
        @(posedge clk_i);
        cyc++;
        if (!in_rst) begin
            if (hsync_in_i && !hs_prev) begin
                prv_start = ctx_start;
                prv_len   = ctx_len;
                prv_cnt   = ctx_cnt;
                prv_valid = ctx_valid;
                prv_tim   = ctx_tim;
                prv_data  = ctx_data;
                ctx_start = cyc;
                ctx_cnt   = cur_q.size();
                ctx_len   = (ctx_cnt < 2) ? 2 : ctx_cnt;
                ctx_valid = cur_valid;
                ctx_tim   = 1'b1;
                for (int i = 0; i < ctx_cnt; i++) ctx_data[i] = cur_q[i];
                cur_q.delete();
                cur_valid = 1'b1;
                m_vs      = vsync_in_i;
                m_vb      = vblank_in_i;
            end
            hs_prev = hsync_in_i;
            if (ce_pix_i && cur_q.size() < 128) cur_q.push_back({video_in_i, hblank_in_i});
        end
        #1;
        if (!in_rst) begin
            e.cyc  = cyc;
            e.obs  = obs_vec();
            e.exp  = 7'd0;
            e.mask = 7'b0000011;
            e.exp[1] = m_vs;
            e.exp[0] = m_vb;
            if (ctx_tim) begin
                e.exp[2]  = (((cyc - ctx_start) / ctx_len) % 2) != 0;
                e.mask[2] = 1'b1;
            end
            use_ctx = (cyc >= ctx_start + 2);
            c_start = use_ctx ? ctx_start : prv_start;
            c_len   = use_ctx ? ctx_len   : prv_len;
            c_cnt   = use_ctx ? ctx_cnt   : prv_cnt;
            c_valid = use_ctx ? ctx_valid : prv_valid;
            c_tim   = use_ctx ? ctx_tim   : prv_tim;
            j = cyc - 2 - c_start;
            if (c_tim && j >= 0) begin
                idx = j % c_len;
                ph  = (j / c_len) % 2;
                e.exp[5]  = (idx < 8);
                e.mask[5] = 1'b1;
                if (c_valid && idx < c_cnt) begin
                    px = use_ctx ? ctx_data[idx] : prv_data[idx];
                    v  = px[1];
`ifdef PIXIE_SCANLINES_EN
                    if (ph != 0) v = 1'b0;
`endif
                    e.exp[6]  = v;
                    e.exp[4]  = px[0];
                    e.exp[3]  = !px[0] && !m_vb;
                    e.mask[6] = 1'b1;
                    e.mask[4] = 1'b1;
                    e.mask[3] = 1'b1;
                end
            end
            log_q.push_back(e);
        end
    endtask

    task automatic drive_clk(input logic ce, input logic v, input logic hs,
                             input logic hb, input logic vs, input logic vb);
        ce_pix_i    = ce;
        video_in_i  = v;
        hsync_in_i  = hs;
        hblank_in_i = hb;
        vsync_in_i  = vs;
        vblank_in_i = vb;
        tick();
    endtask

    // mode: 0 = 1010..., 1 = all ones, 2 = random. vs/vb are presented only
    // on the line-start clock; other clocks carry random values.
    task automatic drive_line(input int n, input int hs_w, input int mode,
                              input logic vs, input logic vb, input bit skew);
        logic v, hb, hs;
        bit   first;
        first = 1'b1;
        if (skew) begin
            drive_clk(1'b0, 1'b0, 1'b1, 1'b0, vs, vb);
            first = 1'b0;
        end
        for (int p = 0; p < n; p++) begin
            case (mode)
                0:       v = (p % 2 == 0);
                1:       v = 1'b1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            hb = (p >= n - 1 - n / 8);
            hs = (p < hs_w);
            drive_clk(1'b1, v, hs, hb,
                      first ? vs : 1'($urandom_range(0, 1)),
                      first ? vb : 1'($urandom_range(0, 1)));
            first = 1'b0;
            drive_clk(1'b0, v, hs, hb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic idle_clks(input int n);
        for (int i = 0; i < n; i++)
            drive_clk(1'(i % 2 == 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        ce_pix_i = 0; video_in_i = 0; hsync_in_i = 0; hblank_in_i = 0;
        vsync_in_i = 0; vblank_in_i = 0;
        reset_i = 1'b0;
        #1 reset_i = 1'b1;
        in_rst = 1'b1;
        #2;
        vecs++;
        if (obs_vec() !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b exp=0000000", obs_vec());
        end
        repeat (3) tick();
        reset_i = 1'b0;
        in_rst  = 1'b0;
        model_reset();
        // Default length governs the free-running replay until the first line start.
        idle_clks(300);
        foreach (log_q[i]) begin
            vecs++;
            if (((log_q[i].obs ^ log_q[i].exp) & log_q[i].mask) != 7'd0) begin
                miscompares++;
                $display("FAIL reset_default cyc=%0d got=%b exp=%b mask=%b",
                         log_q[i].cyc, log_q[i].obs, log_q[i].exp, log_q[i].mask);
            end
        end
        log_q.delete();
    endtask

    task automatic test_basic_replay();
        repeat (3) drive_line(112, 12, 0, 1'b0, 1'b0, 1'b0);
        foreach (log_q[i]) begin
            vecs++;
            if (((log_q[i].obs ^ log_q[i].exp) & log_q[i].mask) != 7'd0) begin
                miscompares++;
                $display("FAIL basic_replay cyc=%0d got=%b exp=%b mask=%b",
                         log_q[i].cyc, log_q[i].obs, log_q[i].exp, log_q[i].mask);
            end
        end
        log_q.delete();
    endtask

    task automatic test_length();
        drive_line(100, 10, 2, 1'b0, 1'b1, 1'b0);
        drive_line(112, 12, 2, 1'b1, 1'b0, 1'b0);
        drive_line(3, 1, 2, 1'b0, 1'b0, 1'b0);
        drive_line(112, 12, 2, 1'b0, 1'b0, 1'b0);
        foreach (log_q[i]) begin
            vecs++;
            if (((log_q[i].obs ^ log_q[i].exp) & log_q[i].mask) != 7'd0) begin
                miscompares++;
                $display("FAIL length_measure cyc=%0d got=%b exp=%b mask=%b",
                         log_q[i].cyc, log_q[i].obs, log_q[i].exp, log_q[i].mask);
            end
        end
        log_q.delete();
    endtask

    task automatic test_overlong();
        drive_line(112, 12, 2, 1'b0, 1'b0, 1'b0);
        drive_line(150, 12, 2, 1'b0, 1'b0, 1'b0);
        drive_line(112, 12, 2, 1'b0, 1'b0, 1'b0);
        drive_line(112, 12, 2, 1'b0, 1'b0, 1'b0);
        foreach (log_q[i]) begin
            vecs++;
            if (((log_q[i].obs ^ log_q[i].exp) & log_q[i].mask) != 7'd0) begin
                miscompares++;
                $display("FAIL overlong cyc=%0d got=%b exp=%b mask=%b",
                         log_q[i].cyc, log_q[i].obs, log_q[i].exp, log_q[i].mask);
            end
        end
        log_q.delete();
    endtask

    task automatic test_simultaneous();
        // Equal lengths put each LS on the replay's last index.
        drive_line(64, 6, 2, 1'b1, 1'b1, 1'b0);
        drive_line(64, 6, 2, 1'b0, 1'b1, 1'b0);
        drive_line(64, 6, 2, 1'b1, 1'b0, 1'b0);
        // Line starts that fall on a clock without ce_pix.
        drive_line(60, 5, 2, 1'b0, 1'b0, 1'b1);
        drive_line(61, 5, 2, 1'b1, 1'b0, 1'b1);
        drive_line(61, 5, 2, 1'b0, 1'b0, 1'b0);
        foreach (log_q[i]) begin
            vecs++;
            if (((log_q[i].obs ^ log_q[i].exp) & log_q[i].mask) != 7'd0) begin
                miscompares++;
                $display("FAIL simultaneous cyc=%0d got=%b exp=%b mask=%b",
                         log_q[i].cyc, log_q[i].obs, log_q[i].exp, log_q[i].mask);
            end
        end
        log_q.delete();
    endtask

    task automatic test_stall();
        drive_line(80, 8, 2, 1'b1, 1'b1, 1'b0);
        drive_line(80, 8, 2, 1'b1, 1'b1, 1'b0);
        idle_clks(4 * 2 * 80);
        drive_line(80, 8, 2, 1'b0, 1'b0, 1'b0);
        drive_line(80, 8, 2, 1'b0, 1'b0, 1'b0);
        foreach (log_q[i]) begin
            vecs++;
            if (((log_q[i].obs ^ log_q[i].exp) & log_q[i].mask) != 7'd0) begin
                miscompares++;
                $display("FAIL stalled_input cyc=%0d got=%b exp=%b mask=%b",
                         log_q[i].cyc, log_q[i].obs, log_q[i].exp, log_q[i].mask);
            end
        end
        log_q.delete();
    endtask

    task automatic test_back_to_back();
        int n, w;
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(2, 140);
            w = $urandom_range(1, (n - 1 < 12) ? n - 1 : 12);
            drive_line(n, w, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        end
        foreach (log_q[i]) begin
            vecs++;
            if (((log_q[i].obs ^ log_q[i].exp) & log_q[i].mask) != 7'd0) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b mask=%b",
                         log_q[i].cyc, log_q[i].obs, log_q[i].exp, log_q[i].mask);
            end
        end
        log_q.delete();
    endtask

    task automatic test_scanlines();
        repeat (3) drive_line(112, 12, 1, 1'b0, 1'b0, 1'b0);
        foreach (log_q[i]) begin
            vecs++;
            if (((log_q[i].obs ^ log_q[i].exp) & log_q[i].mask) != 7'd0) begin
                miscompares++;
                $display("FAIL scanlines cyc=%0d got=%b exp=%b mask=%b",
                         log_q[i].cyc, log_q[i].obs, log_q[i].exp, log_q[i].mask);
            end
        end
        log_q.delete();
    endtask

    task automatic test_reset_mid();
        drive_line(112, 12, 1, 1'b1, 1'b1, 1'b0);
        drive_line(112, 12, 1, 1'b1, 1'b1, 1'b0);
        drive_line(50, 12, 1, 1'b1, 1'b1, 1'b0);
        ce_pix_i = 0; hsync_in_i = 0;
        #2 reset_i = 1'b1;
        in_rst = 1'b1;
        #1;
        vecs++;
        if (obs_vec() !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs got=%b exp=0000000", obs_vec());
        end
        repeat (3) tick();
        reset_i = 1'b0;
        in_rst  = 1'b0;
        model_reset();
        idle_clks(260);
        drive_line(112, 12, 2, 1'b0, 1'b0, 1'b0);
        drive_line(112, 12, 2, 1'b0, 1'b0, 1'b0);
        drive_line(112, 12, 2, 1'b0, 1'b0, 1'b0);
        foreach (log_q[i]) begin
            vecs++;
            if (((log_q[i].obs ^ log_q[i].exp) & log_q[i].mask) != 7'd0) begin
                miscompares++;
                $display("FAIL reset_mid_recover cyc=%0d got=%b exp=%b mask=%b",
                         log_q[i].cyc, log_q[i].obs, log_q[i].exp, log_q[i].mask);
            end
        end
        log_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_replay();
        test_length();
        test_overlong();
        test_simultaneous();
        test_stall();
        test_back_to_back();
        test_scanlines();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/pixie_scandoubler.md
# pixie_scandoubler

Line-doubling scan converter downstream of the CDP1861 Pixie video generator. Captures each incoming 1-bit Pixie line (pixel + blanking) into a ping-pong line buffer at the pixel rate. Replays the previous line twice at the full `clk` rate, doubling the line rate for 31 kHz displays. Sits between `pixie_video` outputs and the top-level video mux.

## Interface
- `MAX_LINE`, 128, line buffer depth in pixels per bank; 7-bit index.
- `DEFAULT_LEN`, 112, line length used until the first full line is measured.
- `HS_LEN`, 8, output hsync width in `clk` cycles.
- `clk` in 1: system clock, equal to 2× the Pixie pixel rate.
- `reset` in 1: asynchronous, active-high.
- `ce_pix` in 1: input pixel strobe, asserted every second `clk`.
- `video_in` in 1: Pixie pixel.
- `hsync_in` in 1: Pixie HSync, active-high.
- `vsync_in` in 1: Pixie VSync, active-high.
- `hblank_in` in 1: Pixie HBlank.
- `vblank_in` in 1: Pixie VBlank.
- `video_out` out 1: doubled pixel.
- `hsync_out` out 1: doubled-rate hsync, active-high.
- `vsync_out` out 1: vsync, line-aligned.
- `hblank_out` out 1: replayed hblank.
- `vblank_out` out 1: vblank, line-aligned.
- `de_out` out 1: `~hblank_out & ~vblank_out`.
- `line_phase` out 1: 0 on the first replay of a line, 1 on the second.

## Operation
- **Edge detect.** `hs_d` registers `hsync_in` every `clk`. A line start (LS) is `hsync_in & ~hs_d`. LS is independent of `ce_pix`.
- **Write side.** `in_x` (8 bit) increments on each `ce_pix`. On each `ce_pix` with `in_x < MAX_LINE`, `{video_in, hblank_in}` is written to `buf[wbank][in_x]`. At `in_x ≥ MAX_LINE` writes stop and `in_x` saturates at `MAX_LINE`.
- **On LS:**
  - `in_len <= in_x`, clamped to 2..`MAX_LINE`.
  - `in_x <= 0`.
  - `wbank` toggles.
  - `vsync_out <= vsync_in` and `vblank_out <= vblank_in`.
  - Read side restarts.
  - LS with `ce_pix` in the same cycle: that pixel is written to the new bank at index 0, and `in_x` becomes 1.
- **Read side.** `out_x` (8 bit) increments every `clk`. The read bank is `~wbank`.
  - When `out_x == in_len-1` and no LS is present: `out_x <= 0` and `line_phase` toggles (second replay).
  - LS has priority: `out_x <= 0` and `line_phase <= 0`.
  - If `out_x` runs past the second replay without an LS (input stalled), it keeps wrapping and `line_phase` keeps toggling. Output stays periodic.
- **Read path.** The buffer read is registered, then the outputs are registered: `{video_out, hblank_out} <= buf[~wbank][out_x_d]`.
- **Hsync.** `hsync_out` is high while the pipelined `out_x` < `HS_LEN`.
- **Buffer storage.** Two banks × `MAX_LINE` × 2 bits, inferred RAM, one write port and one read port.

## Timing
- **Reset values.** All outputs 0. `in_x=0`, `out_x=0`, `wbank=0`, `line_phase=0`, `in_len=DEFAULT_LEN`, `hs_d=0`. Buffer contents are undefined; the first line after reset may show garbage.
- **LS timing.** `hsync_in` sampled high at edge k after being low at k-1 means LS is active in cycle k. At edge k+1: `out_x=0`, `wbank` flipped, `line_phase=0`.
- **Latency.** Pixel `out_x=n` appears on `video_out` 2 `clk` after `out_x==n`. `hsync_out` uses the same 2-clk pipeline, so hsync and pixel 0 are aligned. End-to-end latency is one input line plus 3 `clk`.
- **Replay length.** Each replay is `in_len` `clk`, so two replays span exactly one input line of `2·in_len` `clk`.
- **Line-granular signals.** `vsync_out` and `vblank_out` change only on LS, at edge k+1.
- **Mid-operation reset.** Reset asserted mid-line clears everything asynchronously. After release, the next LS restarts normal operation.

## Configuration
- `PIXIE_SCANLINES_EN` defined: when `line_phase==1`, `video_out` is forced to 0. `hblank_out`, `de_out` and syncs are unchanged. This produces a dark-scanline effect.
- `PIXIE_SCANLINES_EN` undefined: both replays are identical and `line_phase` does not affect video.

## Test plan
- **Basic replay.** Reset, then 112-pixel lines with `ce_pix` every 2nd clk, line A pixels alternating 1010…, hsync 12 pixels wide. During line B: `video_out` shows 1010… at 1 pixel per clk, twice. `hsync_out` is high for 8 clk at each replay start. Replay period is 112 clk.
- **Length measurement.** Feed one line of 100 pixels. The next read side uses `in_len=100`: `out_x` wraps at 99 and `line_phase` toggles at clk 100.
- **Overlong line.** Feed 150 pixels. `in_x` saturates at 128, `in_len=128`. No write beyond index 127, and the other bank is unaltered.
- **Simultaneous events.** LS and `ce_pix` in the same cycle: that pixel is stored at new-bank index 0. LS arriving while `out_x==in_len-1`: `line_phase=0` and `out_x=0`, with no toggle.
- **Stalled input.** Hold `hsync_in` low for 4 lines' worth of clk. `out_x` keeps wrapping every `in_len` clk, `line_phase` toggles each wrap, and `vsync_out` holds its value.
- **Scanlines and reset.** With `PIXIE_SCANLINES_EN`: all-ones line gives `video_out=1` on the first replay and `video_out=0` on the second. Assert `reset` mid-replay: all outputs are 0 within the same cycle, and `in_len=112` after release.
